// File: rtl/mcu_bus_pkg.sv
// mcu_bus_pkg: address map, word geometry and state enum shared by the MCU bus writer and readback blocks
package mcu_bus_pkg;
  localparam logic [7:0] WR_ADDR_FIRST = 8'h00;
  localparam logic [7:0] WR_ADDR_LAST = 8'h0F;
  localparam logic [7:0] RB_OFF_0 = 8'd0;
  localparam logic [7:0] RB_OFF_1 = 8'd1;
  localparam logic [7:0] RB_OFF_2 = 8'd2;
  localparam logic [7:0] RB_OFF_3 = 8'd3;
  localparam logic [7:0] RB_OFF_VERSION = 8'd4;
  localparam int BYTES_PER_WORD = 6;
  typedef enum logic {IDLE, ACTIVE} rb_state_e;
endpackage

// File: rtl/mcu_strobe_sync.sv
// mcu_strobe_sync: two-stage synchronizer for an idle-high MCU strobe with fall/rise pulses
module mcu_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic level,
  output logic fall,
  output logic rise
);
  logic ireg_d, ireg_q, dly_d, dly_q;
  always_comb begin
    ireg_d = strobe;
    dly_d = ireg_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ireg_q <= 1'b1;
      dly_q <= 1'b1;
    end else begin
      ireg_q <= ireg_d;
      dly_q <= dly_d;
    end
  end
  assign level = ireg_q;
  assign fall = ~ireg_q & dly_q;
  assign rise = ireg_q & ~dly_q;
endmodule

// File: rtl/mcu_readback.sv
// mcu_readback: snapshots a selected 48-bit status word and returns it MSB-first, one byte per MCU read strobe
module mcu_readback
  import mcu_bus_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'h10,
  parameter logic [47:0] VERSION_ID = 48'h000000000001
) (
  input  logic        i_main_clk,
  input  logic        i_reset,
  input  logic        i_read_strobe,
  input  logic        i_control_strobe,
  input  logic [7:0]  i_data,
  input  logic [47:0] i_readback_0,
  input  logic [47:0] i_readback_1,
  input  logic [47:0] i_readback_2,
  input  logic [47:0] i_readback_3,
  output logic [7:0]  o_data,
  output logic        o_data_oe,
  output logic        o_transfer_active
);
  logic rd_level, rd_fall, rd_rise, ctl_level, ctl_fall, ctl_rise;
  logic unused_sync;
  logic [7:0] data_d, data_q, off, out_d, out_q;
  logic [47:0] src, shreg_d, shreg_q;
  logic [2:0] rem_d, rem_q;
  logic load, oe_d, oe_q, act_d, act_q;
  rb_state_e state_d, state_q;

  mcu_strobe_sync u_rd_sync (
    .clk(i_main_clk), .rst(i_reset), .strobe(i_read_strobe),
    .level(rd_level), .fall(rd_fall), .rise(rd_rise)
  );
  mcu_strobe_sync u_ctl_sync (
    .clk(i_main_clk), .rst(i_reset), .strobe(i_control_strobe),
    .level(ctl_level), .fall(ctl_fall), .rise(ctl_rise)
  );
  assign unused_sync = &{1'b0, rd_fall, ctl_level, ctl_rise};

  // Offset wraps below BASE_ADDR, so a single unsigned compare bounds both ends.
  assign off = data_q - BASE_ADDR;
  assign load = ctl_fall && off <= RB_OFF_VERSION;
  assign src = off == RB_OFF_0 ? i_readback_0 :
               off == RB_OFF_1 ? i_readback_1 :
               off == RB_OFF_2 ? i_readback_2 :
               off == RB_OFF_3 ? i_readback_3 : VERSION_ID;

  always_comb begin
    data_d = i_data;
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d = rem_q;
    if (load) begin
      state_d = ACTIVE;
      shreg_d = src;
      rem_d = 3'(BYTES_PER_WORD);
    end else if (rd_rise && state_q == ACTIVE) begin
      shreg_d = {shreg_q[39:0], 8'h00};
      rem_d = rem_q - 3'd1;
      state_d = rem_q == 3'd1 ? IDLE : ACTIVE;
    end
    out_d = state_q == ACTIVE ? shreg_q[47:40] : 8'h00;
    oe_d = ~rd_level;
    act_d = state_q == ACTIVE;
  end

  always_ff @(posedge i_main_clk) begin
    if (i_reset) begin
      data_q <= 8'h00;
      state_q <= IDLE;
      shreg_q <= 48'h0;
      rem_q <= 3'd0;
      out_q <= 8'h00;
      oe_q <= 1'b0;
      act_q <= 1'b0;
    end else begin
      data_q <= data_d;
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q <= rem_d;
      out_q <= out_d;
      oe_q <= oe_d;
      act_q <= act_d;
    end
  end

  assign o_data = out_q;
  assign o_data_oe = oe_q;
  assign o_transfer_active = act_q;
endmodule
